// File: rtl/scff_ctrl_pkg.sv
// scff_ctrl_pkg: shared states, mode codes and CRC-16-CCITT constants for the scan-chain sequencer
package scff_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CLEAR, PROBE, RELEASE} state_t;

    localparam logic MODE_PROG = 1'b0;
    localparam logic MODE_TEST = 1'b1;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/scff_chain_ctrl_if.sv
// scff_chain_ctrl_if: command, bitstream handshake and status bundle between management side and sequencer
interface scff_chain_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 11
);
    logic              cmd_start;
    logic              cmd_mode;
    logic [WORD_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  shift_count;
    logic [15:0]       crc_out;

    modport master (
        output cmd_start, cmd_mode, data_in, data_valid,
        input  data_ready, busy, done, pass, shift_count, crc_out
    );

    modport slave (
        input  cmd_start, cmd_mode, data_in, data_valid,
        output data_ready, busy, done, pass, shift_count, crc_out
    );

endinterface

// File: rtl/scff_crc16.sv
// scff_crc16: serial MSB-first CRC-16-CCITT over chain readback bits (built only with SCFF_CTRL_READBACK_EN)
`ifdef SCFF_CTRL_READBACK_EN
module scff_crc16
    import scff_ctrl_pkg::*;
(
    input  logic        prog_clk,
    input  logic        prog_resetb,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge prog_clk or negedge prog_resetb)
        if (!prog_resetb) crc <= 16'h0000;
        else if (clr) crc <= CRC_INIT;
        else if (en) crc <= crc16_step(crc, din);

endmodule
`endif

// File: rtl/scff_chain_ctrl.sv
// scff_chain_ctrl: programs the fabric scan chain from bitstream words or self-tests its length.
// Optional readback CRC of the old chain contents is enabled by SCFF_CTRL_READBACK_EN.
module scff_chain_ctrl
    import scff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN      = 1024,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_MARGIN = 16,
    parameter int RELEASE_CYCLES = 2,
    parameter int CNT_W          = $clog2(CHAIN_LEN + TIMEOUT_MARGIN + 1)
)(
    input  logic               prog_clk,
    input  logic               prog_resetb,
    scff_chain_ctrl_if.slave   bus,
    output logic               sc_head,
    output logic               sc_en,
    input  logic               sc_tail,
    output logic               greset
);

    localparam int BW = $clog2(WORD_W);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [BW-1:0]     bit_cnt;
    logic [RW-1:0]     rel_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              data_ready;
    logic              busy;
    logic              done;
    logic              pass;

    assign cnt_inc         = cnt + CNT_W'(1);
    assign bus.data_ready  = data_ready;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pass        = pass;
    assign bus.shift_count = cnt;

    // sc_en is high for every cycle spent in SHIFT/CLEAR/PROBE, so each edge there is a shift edge
    always_ff @(posedge prog_clk or negedge prog_resetb)
        if (!prog_resetb) begin
            state      <= IDLE;
            word       <= '0;
            bit_cnt    <= '0;
            rel_cnt    <= '0;
            cnt        <= '0;
            data_ready <= 1'b0;
            sc_head    <= 1'b0;
            sc_en      <= 1'b0;
            greset     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (bus.cmd_start) begin
                        done   <= 1'b0;
                        pass   <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        greset <= 1'b1;
                        if (bus.cmd_mode == MODE_PROG) begin
                            state      <= LOAD;
                            data_ready <= 1'b1;
                        end else begin
                            state   <= CLEAR;
                            sc_en   <= 1'b1;
                            sc_head <= 1'b0;
                        end
                    end
                LOAD:
                    if (bus.data_valid) begin
                        state      <= SHIFT;
                        data_ready <= 1'b0;
                        word       <= bus.data_in >> 1;
                        sc_head    <= bus.data_in[0];
                        sc_en      <= 1'b1;
                        bit_cnt    <= '0;
                    end
                SHIFT: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == CNT_W'(CHAIN_LEN)) begin
                        state   <= RELEASE;
                        pass    <= 1'b1;
                        sc_en   <= 1'b0;
                        sc_head <= 1'b0;
                        rel_cnt <= '0;
                    end else if (bit_cnt == BW'(WORD_W - 1)) begin
                        state      <= LOAD;
                        data_ready <= 1'b1;
                        sc_en      <= 1'b0;
                        sc_head    <= 1'b0;
                    end else begin
                        sc_head <= word[0];
                        word    <= word >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                CLEAR:
                    if (cnt_inc == CNT_W'(CHAIN_LEN)) begin
                        state   <= PROBE;
                        cnt     <= '0;
                        sc_head <= 1'b1;
                    end else cnt <= cnt_inc;
                // a tail hit at cnt==0 is stuck-at-1 and can never equal CHAIN_LEN, so it fails naturally
                PROBE:
                    if (sc_tail || cnt == CNT_W'(CHAIN_LEN + TIMEOUT_MARGIN)) begin
                        state   <= RELEASE;
                        pass    <= sc_tail && (cnt == CNT_W'(CHAIN_LEN));
                        sc_en   <= 1'b0;
                        sc_head <= 1'b0;
                        rel_cnt <= '0;
                    end else begin
                        cnt     <= cnt_inc;
                        sc_head <= 1'b0;
                    end
                RELEASE:
                    if (rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
                        state  <= IDLE;
                        greset <= ~pass;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else rel_cnt <= rel_cnt + RW'(1);
                default: state <= IDLE;
            endcase
        end

`ifdef SCFF_CTRL_READBACK_EN
    logic [15:0] crc;

    scff_crc16 u_crc (
        .prog_clk    (prog_clk),
        .prog_resetb (prog_resetb),
        .clr         (state == IDLE && bus.cmd_start),
        .en          (state == SHIFT),
        .din         (sc_tail),
        .crc         (crc)
    );

    assign bus.crc_out = crc;
`else
    assign bus.crc_out = 16'h0000;
`endif

endmodule

// File: tb/tb_scff_chain_ctrl.sv
// tb_scff_chain_ctrl: directed checks of programming, truncation, chain self-test, backpressure and abort
module tb_scff_chain_ctrl;
    import scff_ctrl_pkg::*;

    logic prog_clk = 1'b0;
    logic prog_resetb = 1'b0;
    always #5 prog_clk = ~prog_clk;

    scff_chain_ctrl_if #(.WORD_W(32), .CNT_W(7)) bif ();
    scff_chain_ctrl_if #(.WORD_W(32), .CNT_W(6)) bif40 ();

    logic sc_head, sc_en, sc_tail, greset;
    logic sc_head40, sc_en40, sc_tail40, greset40;

    scff_chain_ctrl #(.CHAIN_LEN(64), .WORD_W(32), .TIMEOUT_MARGIN(16), .RELEASE_CYCLES(2)) dut (
        .prog_clk    (prog_clk),
        .prog_resetb (prog_resetb),
        .bus         (bif),
        .sc_head     (sc_head),
        .sc_en       (sc_en),
        .sc_tail     (sc_tail),
        .greset      (greset)
    );

    scff_chain_ctrl #(.CHAIN_LEN(40), .WORD_W(32), .TIMEOUT_MARGIN(16), .RELEASE_CYCLES(2)) dut40 (
        .prog_clk    (prog_clk),
        .prog_resetb (prog_resetb),
        .bus         (bif40),
        .sc_head     (sc_head40),
        .sc_en       (sc_en40),
        .sc_tail     (sc_tail40),
        .greset      (greset40)
    );

    logic [127:0] ch = '0;
    logic [39:0]  ch40 = '0;
    int mlen = 64;
    int tmode = 0;
    int cyc = 0;
    int last_sh = 0;
    int nsh = 0;
    int nsh40 = 0;
    int hs40 = 0;
    int n_chk = 0;
    int n_fail = 0;

    assign sc_tail   = (tmode == 1) ? 1'b0 : (tmode == 2) ? 1'b1 : ch[mlen-1];
    assign sc_tail40 = ch40[39];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (sc_en) begin
            ch      <= {ch[126:0], sc_head};
            last_sh <= cyc;
            nsh     <= nsh + 1;
        end
        if (sc_en40) begin
            ch40  <= {ch40[38:0], sc_head40};
            nsh40 <= nsh40 + 1;
        end
        if (bif40.data_ready && bif40.data_valid) hs40 <= hs40 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        check(tag, {bif.data_ready, sc_head, sc_en, greset, bif.busy, bif.done, bif.pass, bif.shift_count, bif.crc_out},
              {7'b0001000, 7'd0, 16'h0000});
    endtask

    task automatic start64(input logic mode);
        @(negedge prog_clk);
        bif.cmd_start = 1'b1;
        bif.cmd_mode  = mode;
        @(negedge prog_clk);
        bif.cmd_start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200 && !bif.data_ready; i++) @(negedge prog_clk);
        check(tag, bif.data_ready, 1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && !bif.done; i++) @(negedge prog_clk);
        check(tag, bif.done, 1);
    endtask

    task automatic prog64(input logic [31:0] w0, input logic [31:0] w1, input bit gap);
        int n0;
        start64(MODE_PROG);
        bif.data_in    = w0;
        bif.data_valid = 1'b1;
        wait_ready("p_ready0");
        @(negedge prog_clk);
        bif.data_in = w1;
        if (gap) begin
            bif.data_valid = 1'b0;
            wait_ready("p_ready1");
            n0 = nsh;
            start64(MODE_TEST);
            repeat (8) @(negedge prog_clk);
            check("gap_no_shift", nsh - n0, 0);
            check("busy_start_ignored", {bif.data_ready, sc_en, bif.busy}, 3'b101);
            bif.data_valid = 1'b1;
        end
        wait_done("p_done");
        bif.data_valid = 1'b0;
    endtask

    task automatic test64(input string tag, input int len, input int tm, input int exp_cnt, input bit exp_pass);
        mlen  = len;
        tmode = tm;
        start64(MODE_TEST);
        wait_done(tag);
        check({tag, "_cnt"}, bif.shift_count, exp_cnt);
        check({tag, "_pass"}, bif.pass, exp_pass);
        check({tag, "_greset"}, greset, !exp_pass);
        check({tag, "_busy"}, bif.busy, 0);
    endtask

`ifdef SCFF_CTRL_READBACK_EN
    function automatic logic [15:0] ref_crc(input logic [31:0] w0, input logic [31:0] w1);
        logic [15:0] c = 16'hFFFF;
        logic b;
        for (int k = 0; k < 64; k++) begin
            b = (k < 32) ? w0[k] : w1[k-32];
            c = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    initial begin
        int n0;
        int h0;
        bif.cmd_start = 1'b0;   bif.cmd_mode = 1'b0;   bif.data_in = '0;   bif.data_valid = 1'b0;
        bif40.cmd_start = 1'b0; bif40.cmd_mode = 1'b0; bif40.data_in = '0; bif40.data_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        chk_rst("reset_values");
        prog_resetb = 1'b1;

        n0 = nsh;
        prog64(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
        check("prog_chain", ch[63:0], 64'hA5A5A5A5_F0F0F0F0);
        check("prog_shifts", nsh - n0, 64);
        check("prog_cnt", bif.shift_count, 64);
        check("prog_pass", bif.pass, 1);
        check("prog_greset", greset, 0);
        check("greset_delay", cyc - 1 - last_sh, 2);
        check("prog_crc_idle", bif.crc_out, 16'h0000);
        repeat (3) @(negedge prog_clk);
        check("done_sticky", bif.done, 1);

        @(negedge prog_clk);
        bif40.cmd_start = 1'b1;
        bif40.cmd_mode  = MODE_PROG;
        @(negedge prog_clk);
        bif40.cmd_start  = 1'b0;
        bif40.data_in    = 32'h12345678;
        bif40.data_valid = 1'b1;
        n0 = nsh40;
        h0 = hs40;
        for (int i = 0; i < 200 && !bif40.data_ready; i++) @(negedge prog_clk);
        check("t40_ready", bif40.data_ready, 1);
        @(negedge prog_clk);
        bif40.data_in = 32'h000000C3;
        for (int i = 0; i < 500 && !bif40.done; i++) @(negedge prog_clk);
        check("t40_done", bif40.done, 1);
        repeat (3) @(negedge prog_clk);
        check("t40_chain", ch40, 40'h1E6A2C48C3);
        check("t40_shifts", nsh40 - n0, 40);
        check("t40_handshakes", hs40 - h0, 2);
        check("t40_ready_low", bif40.data_ready, 0);
        check("t40_cnt", bif40.shift_count, 40);
        check("t40_pass", {bif40.pass, greset40}, 2'b10);
        bif40.data_valid = 1'b0;

        test64("test_ok", 64, 0, 64, 1'b1);
        test64("test_short", 63, 0, 63, 1'b0);
        test64("test_tie0", 64, 1, 80, 1'b0);
        test64("test_tie1", 64, 2, 0, 1'b0);
        mlen  = 64;
        tmode = 0;

        prog64(32'h3C3C3C3C, 32'h00FF00FF, 1'b1);
        check("gap_chain", ch[63:0], 64'h3C3C3C3C_FF00FF00);
        check("gap_cnt_pass", {bif.pass, bif.shift_count}, {1'b1, 7'd64});

        start64(MODE_PROG);
        bif.data_in    = 32'hDEADBEEF;
        bif.data_valid = 1'b1;
        wait_ready("abort_ready");
        repeat (5) @(negedge prog_clk);
        check("abort_mid_shift", sc_en, 1);
        #2 prog_resetb = 1'b0;
        #1 chk_rst("abort_values");
        @(negedge prog_clk);
        prog_resetb    = 1'b1;
        bif.data_valid = 1'b0;

`ifdef SCFF_CTRL_READBACK_EN
        prog64(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
        prog64(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
        check("crc_readback", bif.crc_out, ref_crc(32'hA5A5A5A5, 32'h0F0F0F0F));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
